// File: rtl/store_byte_merge_if.sv
// store_byte_merge_if
// Groups the store-request handshake and the data-memory port of the
// byte-merge store unit into one bundle.
//   Request side : req_valid, req_ready, req_addr, req_data, req_size
//   Memory side  : mem_addr, mem_rd_en, mem_rdata, mem_wr_en, mem_wdata
//   Status       : done (store finished), err (request rejected)
// The slave modport is the store unit itself; the master modport is whoever
// issues stores and models the memory.
interface store_byte_merge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
endinterface

// File: rtl/store_byte_merge.sv
// store_byte_merge
// Turns byte / halfword / word stores into whole-word memory writes.
// Sub-word stores do a read-modify-write: read the target word, splice the
// new bytes into their little-endian lanes, write the word back. Word stores
// are written directly. Misaligned or illegal-size requests are rejected
// with a one-cycle err pulse and never touch memory.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - store_byte_merge_if.slave (request handshake, memory port,
//           done/err pulses)
module store_byte_merge (
    input  logic                clk,
    input  logic                reset,
    store_byte_merge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rst_q;
    logic        ready;
    logic        accept;
    logic        bad_req;
    logic        rd_en;
    logic        wr_en;
    logic        done_p;
    logic        err_p;
    logic [29:0] addr_q;
    logic [15:0] data_q;
    logic [1:0]  lane_q;
    logic        half_q;
    logic [31:0] word_q;
    logic [31:0] merged;

    // Delayed copy of reset keeps req_ready low for the whole reset period
    // while still letting it rise in the first cycle after reset is released.
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    assign ready  = (state == IDLE) && !rst_q;
    assign accept = bus.req_valid && ready;

    // Alignment / size legality of the request currently on the bus.
    always_comb begin
        bad_req = 1'b0;
        case (bus.req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = bus.req_addr[0];
            2'b10:   bad_req = (bus.req_addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are decoded purely from state so each one is exactly one
    // cycle wide and read/write can never overlap.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        done_p    = 1'b0;
        err_p     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_req) begin
                        state_nxt = ERR;
                    end else if (bus.req_size == 2'b10) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                rd_en     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                wr_en     = 1'b1;
                done_p    = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err_p     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Splice the captured store data into the word returned by memory;
    // every lane not being stored passes through untouched.
    always_comb begin
        merged = bus.mem_rdata;
        if (half_q) begin
            if (lane_q[1]) begin
                merged[31:16] = data_q;
            end else begin
                merged[15:0] = data_q;
            end
        end else begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // word_q is the outgoing write word: loaded with the full register value
    // on accept (already correct for word stores), then overwritten with the
    // merged read data during WAIT for sub-word stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            lane_q <= '0;
            half_q <= 1'b0;
            word_q <= '0;
        end else if (accept) begin
            addr_q <= bus.req_addr[31:2];
            data_q <= bus.req_data[15:0];
            lane_q <= bus.req_addr[1:0];
            half_q <= (bus.req_size == 2'b01);
            word_q <= bus.req_data;
        end else if (state == WAIT) begin
            word_q <= merged;
        end
    end

    assign bus.req_ready = ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_wdata = word_q;
    assign bus.done      = done_p;
    assign bus.err       = err_p;

endmodule

// File: doc/store_byte_merge.md
STORE_BYTE_MERGE -- requirements
Module: store_byte_merge

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 32-bit byte addresses.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_addr  input  32  byte address of the store.
REQ-007 req_data  input  32  register value; byte stores use [7:0], halfword stores use [15:0].
REQ-008 req_size  input  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal.
REQ-009 mem_addr  output  30  word address to data memory, equal to the captured req_addr[31:2].
REQ-010 mem_rd_en  output  1  word read strobe; mem_rdata is valid exactly one cycle later.
REQ-011 mem_rdata  input  32  word read data.
REQ-012 mem_wr_en  output  1  word write strobe, one cycle wide.
REQ-013 mem_wdata  output  32  merged word to write.
REQ-014 done  output  1  one-cycle pulse when the store completes.
REQ-015 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 A request SHALL be accepted when req_valid and req_ready are both high on a rising edge; addr, data and size are captured on that edge.
REQ-017 req_ready SHALL be high only in IDLE and SHALL be low in the cycle following reset assertion.
REQ-018 The FSM SHALL have the states IDLE, READ, WAIT, WRITE and ERR.
REQ-019 From IDLE on accept: illegal size, a halfword with addr[0]=1, or a word with addr[1:0]!=0 -> ERR; a word -> WRITE; a byte or halfword -> READ.
REQ-020 READ SHALL assert mem_rd_en for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL capture mem_rdata into an internal word register and merge the new data into it, then go to WRITE.
REQ-022 Byte lanes SHALL be little-endian: a byte store replaces bits [8*a+7:8*a] with a=addr[1:0]; a halfword store replaces [15:0] when addr[1]=0 and [31:16] when addr[1]=1.
REQ-023 All unreplaced bits SHALL equal mem_rdata unchanged; no sign or zero extension SHALL be applied.
REQ-024 A word store SHALL write req_data unchanged without a read.
REQ-025 WRITE SHALL assert mem_wr_en and done together for one cycle with mem_wdata valid, then return to IDLE.
REQ-026 ERR SHALL assert err for one cycle with no memory strobe, then return to IDLE.
REQ-027 Latency from the accept edge: word, done in cycle +1; byte or halfword, mem_rd_en in cycle +1 and done in cycle +3; error, err in cycle +1.
REQ-028 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-029 mem_addr SHALL hold the captured word address from the accept edge until the return to IDLE.
REQ-030 req_valid while busy SHALL be ignored, not queued; back-to-back requests therefore have a minimum spacing of 2 cycles (word) or 4 cycles (byte/halfword).

Reset
REQ-031 On reset the FSM SHALL enter IDLE, and req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 On reset mem_rd_en, mem_wr_en, done and err SHALL be 0, and mem_addr, mem_wdata and the internal registers SHALL be 0.
REQ-033 Reset asserted in any state SHALL abort the operation, and no write SHALL issue in the cycle after reset asserts.

Verification
REQ-034 sb: addr=0x00000102, data=0x000000AB, mem_rdata=0x11223344 -> mem_rd_en at +1 with mem_addr=0x40, then mem_wdata=0x11AB3344 with mem_wr_en and done at +3.
REQ-035 sh: addr=0x00000006, data=0xFFFF8001, mem_rdata=0xDEADBEEF -> mem_wdata=0x8001BEEF at +3; sh with addr=0x00000005 -> err at +1 with no strobes.
REQ-036 sw: addr=0x00000010, data=0xCAFEF00D -> mem_wr_en and done at +1 with mem_addr=0x4 and mem_wdata=0xCAFEF00D; mem_rd_en never asserted.
REQ-037 req_size=11 -> err at +1 with no strobes; req_valid held high during a byte store -> exactly one write, and the next accept occurs in the IDLE cycle after done.
REQ-038 Reset asserted in WAIT of a byte store -> no mem_wr_en and no done, all outputs 0, and req_ready=1 in the cycle after reset deasserts.
REQ-039 sb to each of lanes 0-3 with mem_rdata=0x00000000 and data=0xFF -> mem_wdata equals 0x000000FF, 0x0000FF00, 0x00FF0000 and 0xFF000000 respectively.
